// File: rtl/cpu_pkg.sv
// Shared datapath constants and helpers for the CPU datapath blocks.
package cpu_pkg;

    // Default datapath width.
    localparam int unsigned DATA_W = 32;

    // Arbitration mode selectors.
    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    // Ceiling log2, for tools that lack $clog2. clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way arbiter: fixed priority (lowest index) or round-robin
// starting at ptr, built as a double-width masked priority search.
module rr_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned RR    = ARB_RR,
    parameter int unsigned SEL_W = clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] grant_idx
);

    logic [N-1:0]   mask;
    logic [2*N-1:0] req_dbl;
    logic           found;

    // Low half keeps only requests at or above the pointer; the high half is the
    // full request vector, which supplies the wrap-around candidates.
    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            if (RR == ARB_RR) begin
                mask[i] = (i >= int'(ptr));
            end else begin
                mask[i] = 1'b1;
            end
        end
        req_dbl = {req, req & mask};
    end

    // First set bit of the doubled vector, folded back into 0..N-1.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < 2 * N; k++) begin
            if (!found && req_dbl[k]) begin
                found     = 1'b1;
                grant_idx = SEL_W'(k % N);
            end
        end
    end

    // One-hot expansion of the winning index.
    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = found && (grant_idx == SEL_W'(i));
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N-input registered multiplexer with an internal arbiter, valid/ready on both
// sides and a single output register stage that refills in the draining cycle.
module rr_arb_mux
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W,
    parameter int unsigned N     = 4,
    parameter int unsigned RR    = ARB_RR,
    parameter int unsigned SEL_W = clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    input  logic               out_ready
);

    // Elaboration-time parameter sanity.
    if (N < 2 || N > 16) begin : g_bad_n
        $error("rr_arb_mux: N must be within 2..16");
    end
    if (RR != ARB_FIXED && RR != ARB_RR) begin : g_bad_rr
        $error("rr_arb_mux: RR must be 0 or 1");
    end

    logic [N-1:0]     grant;
    logic [SEL_W-1:0] grant_idx;
    logic             load_en;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    rr_arbiter #(
        .N     (N),
        .RR    (RR),
        .SEL_W (SEL_W)
    ) u_arbiter (
        .req       (in_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Stage can take a beat when empty or when the current beat drains now.
    // in_ready is held low during reset even though the stage reads as empty.
    always_comb begin
        load_en  = !out_valid_q || out_ready;
        in_ready = '0;
        if (!rst) begin
            in_ready = grant & {N{load_en}};
        end
        // Grant is a subset of in_valid, so any ready bit is a transfer.
        xfer = |in_ready;
    end

    // One-hot AND-OR data select driven by the grant vector.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output stage and round-robin pointer next state.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            if (xfer) begin
                out_valid_d = 1'b1;
                out_data_d  = sel_data;
                out_sel_d   = grant_idx;
                if (RR == ARB_RR) begin
                    if (grant_idx == SEL_W'(N - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = grant_idx + 1'b1;
                    end
                end
            end else begin
                // Drain with nothing to replace it: data and index keep their value.
                out_valid_d = 1'b0;
            end
        end
    end

    // State registers with asynchronous reset discarding any pending beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: a round-robin and a fixed-priority instance share the
// same stimulus; a queue-free behavioural model is checked every falling edge,
// and directed literal expectations pin the model on the documented scenarios.
module tb_rr_arb_mux;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   in_valid = '0;
    logic [N*W-1:0] in_data = '0;
    logic           out_ready = 1'b0;

    logic [N-1:0] rdy_rr, rdy_fx;
    logic         ov_rr, ov_fx;
    logic [W-1:0] od_rr, od_fx;
    logic [1:0]   os_rr, os_fx;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rr_arb_mux #(.WIDTH(W), .N(N), .RR(1)) dut_rr (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (rdy_rr),
        .out_valid (ov_rr),
        .out_data  (od_rr),
        .out_sel   (os_rr),
        .out_ready (out_ready)
    );

    rr_arb_mux #(.WIDTH(W), .N(N), .RR(0)) dut_fx (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (rdy_fx),
        .out_valid (ov_fx),
        .out_data  (od_fx),
        .out_sel   (os_fx),
        .out_ready (out_ready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (index 0 = round-robin, 1 = fixed) ----
    logic         m_v[2];
    logic [W-1:0] m_d[2];
    logic [1:0]   m_s[2];
    logic [1:0]   m_p;

    // Channel the rules select for the given requests, or -1 when none.
    function automatic int pick(input logic [N-1:0] v, input int p, input bit rr);
        for (int k = 0; k < N; k++) begin
            int c;
            c = rr ? (p + k) % N : k;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic int pick_u(input int u);
        return pick(in_valid, (u == 0) ? int'(m_p) : 0, u == 0);
    endfunction

    function automatic logic [N-1:0] exp_rdy(input int u);
        int idx;
        idx = pick_u(u);
        if (rst || idx < 0 || !(!m_v[u] || out_ready)) return '0;
        return 4'b0001 << idx;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int u = 0; u < 2; u++) begin
                m_v[u] <= 1'b0;
                m_d[u] <= '0;
                m_s[u] <= '0;
            end
            m_p <= '0;
        end else begin
            for (int u = 0; u < 2; u++) begin
                if (!m_v[u] || out_ready) begin
                    if (pick_u(u) >= 0) begin
                        m_v[u] <= 1'b1;
                        m_d[u] <= in_data[pick_u(u)*W +: W];
                        m_s[u] <= 2'(pick_u(u));
                        if (u == 0) m_p <= 2'((pick_u(u) + 1) % N);
                    end else begin
                        m_v[u] <= 1'b0;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("in_ready_rr", rdy_rr, exp_rdy(0));
        check("in_ready_fx", rdy_fx, exp_rdy(1));
        check("out_valid_rr", ov_rr, m_v[0]);
        check("out_valid_fx", ov_fx, m_v[1]);
        check("out_data_rr", od_rr, m_d[0]);
        check("out_data_fx", od_fx, m_d[1]);
        check("out_sel_rr", os_rr, m_s[0]);
        check("out_sel_fx", os_fx, m_s[1]);
        check("ptr_rr", dut_rr.ptr_q, m_p);
    end

    // ---------------- directed stimulus ----------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) cyc();
        check("reset_valid", ov_rr, 1'b0);
        rst = 1'b0;

        // Single source on channel 2.
        in_data[2*W +: W] = 32'hDEAD_BEEF;
        in_data[0 +: W]   = 32'h0000_1000;
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        #2;
        check("single_rdy_rr", rdy_rr, 4'b0100);
        check("single_rdy_fx", rdy_fx, 4'b0100);
        cyc();
        in_valid = 4'b0000;
        #2;
        check("single_valid", ov_rr, 1'b1);
        check("single_data", od_rr, 32'hDEAD_BEEF);
        check("single_sel", os_rr, 2'd2);
        check("single_ptr", dut_rr.ptr_q, 2'd3);

        // Drain to empty: valid falls, data and index hold.
        cyc();
        #2;
        check("drain_valid", ov_rr, 1'b0);
        check("drain_data", od_rr, 32'hDEAD_BEEF);
        check("drain_sel", os_rr, 2'd2);

        // Load a beat, stall it, then reset asynchronously mid-cycle.
        cyc();
        in_data[0 +: W] = 32'h1111_1111;
        in_valid = 4'b0001;
        cyc();
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        #2;
        check("pre_reset_valid", ov_rr, 1'b1);
        in_valid = 4'b1111;
        rst = 1'b1;
        #1;
        check("async_valid", ov_rr, 1'b0);
        check("async_data", od_rr, 32'h0);
        check("async_sel", os_rr, 2'd0);
        check("async_rdy_rr", rdy_rr, 4'b0000);
        check("async_rdy_fx", rdy_fx, 4'b0000);

        // Round-robin fairness with all channels requesting.
        cyc();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'hC0DE_0000 | i;
        for (int k = 0; k < 8; k++) begin
            cyc();
            #2;
            check("rr_seq_sel", os_rr, 64'(k % N));
            check("rr_seq_ptr", dut_rr.ptr_q, 64'((k + 1) % N));
            check("fx_seq_sel", os_fx, 2'd0);
        end

        // Fixed priority starves channel 3.
        in_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            cyc();
            #2;
            check("fx_prio_sel", os_fx, 2'd1);
            check("fx_prio_data", od_fx, 32'hC0DE_0001);
        end

        // Back-pressure: RR last granted 1 (pointer 2).
        out_ready = 1'b0;
        in_valid  = 4'b0011;
        #1;
        check("bp_rdy_rr", rdy_rr, 4'b0000);
        check("bp_rdy_fx", rdy_fx, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            cyc();
            #2;
            check("bp_hold_rdy", rdy_rr, 4'b0000);
            check("bp_hold_valid", ov_rr, 1'b1);
            check("bp_hold_sel", os_rr, 2'd1);
            check("bp_hold_data", od_rr, 32'hC0DE_0001);
            check("bp_hold_ptr", dut_rr.ptr_q, 2'd2);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_rr", rdy_rr, 4'b0001);
        check("bp_release_fx", rdy_fx, 4'b0001);
        cyc();
        #2;
        check("no_bubble_valid", ov_rr, 1'b1);
        check("no_bubble_sel", os_rr, 2'd0);
        check("no_bubble_data", od_rr, 32'hC0DE_0000);
        check("no_bubble_ptr", dut_rr.ptr_q, 2'd1);
        check("no_bubble_rdy", rdy_rr, 4'b0010);

        // Drain the last beat.
        in_valid = 4'b0000;
        cyc();
        #2;
        check("final_valid", ov_rr, 1'b0);
        check("final_data", od_rr, 32'hC0DE_0000);
        check("final_sel", os_rr, 2'd0);
        repeat (2) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
